// File: rtl/adder32_nibble_seq_pkg.sv
// Shared constants for the nibble-serial 32-bit add/subtract unit.
// Holds the FSM state encoding, slice count and result width.
package adder32_nibble_seq_pkg;

   localparam int WIDTH   = 32;
   localparam int NIBBLES = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/adder32_nibble_seq_adder_4bits.sv
// Combinational 4-bit ripple adder, the single arithmetic slice that
// the controller time-shares across all eight nibbles.
module adder_4bits (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);

   assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0000, ci};

endmodule

// File: rtl/adder32_nibble_seq.sv
// Multi-cycle 32-bit add/subtract: one nibble per clock through a shared
// 4-bit adder, with a start/busy/done handshake.
module adder32_nibble_seq
   import adder32_nibble_seq_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [WIDTH-1:0]    a,
   input  logic [WIDTH-1:0]    b,
   input  logic                cin,
   input  logic                sub,
   output logic                busy,
   output logic                done,
   output logic [WIDTH-1:0]    sum,
   output logic                cout,
   output logic                ovf
);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic [2:0]         idx_q, idx_d;
   logic               carry_q, carry_d;
   logic               cout_q, cout_d;
   logic               ovf_q, ovf_d;

   logic [3:0]         nib_a, nib_b, nib_s;
   logic               nib_co;
   logic [4:0]         bit_base;

   assign bit_base = {idx_q, 2'b00};
   assign nib_a    = a_q[bit_base +: 4];
   assign nib_b    = b_q[bit_base +: 4];

   adder_4bits u_add (
      .a  (nib_a),
      .b  (nib_b),
      .ci (carry_q),
      .s  (nib_s),
      .co (nib_co)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         ST_RUN: begin
            sum_d[bit_base +: 4] = nib_s;
            carry_d              = nib_co;
            if (idx_q == 3'(NIBBLES - 1)) begin
               // Final slice: flags come straight from the adder so they land with DONE.
               state_d = ST_DONE;
               cout_d  = nib_co;
               ovf_d   = (a_q[WIDTH-1] ~^ b_q[WIDTH-1]) & (nib_s[3] ^ a_q[WIDTH-1]);
            end else begin
               idx_d = idx_q + 3'd1;
            end
         end
         default: begin
            if (start) begin
               state_d = ST_RUN;
               a_d     = a;
               b_d     = sub ? ~b : b;
               carry_d = sub ? 1'b1 : cin;
               idx_d   = '0;
               sum_d   = '0;
               cout_d  = 1'b0;
               ovf_d   = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
      endcase
   end

   assign busy = (state_q == ST_RUN);
   assign done = (state_q == ST_DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_adder32_nibble_seq.sv
// Scoreboard bench: stimulus pushes expected results computed with plain
// 33-bit / signed arithmetic; a monitor pops and checks on every done pulse.
module tb_adder32_nibble_seq;

   logic        clk = 1'b0;
   logic        rst, start, cin, sub;
   logic [31:0] a, b;
   logic        busy, done, cout, ovf;
   logic [31:0] sum;

   typedef struct {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   run_len = 0;

   adder32_nibble_seq dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .sub   (sub),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                  input logic ci, input logic s);
      exp_t        e;
      logic [32:0] u;
      longint      exact;
      if (s) begin
         u     = {1'b0, x} + {1'b0, ~y} + 33'd1;
         exact = longint'($signed(x)) - longint'($signed(y));
      end else begin
         u     = {1'b0, x} + {1'b0, y} + {32'd0, ci};
         exact = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
      end
      e.sum  = u[31:0];
      e.cout = u[32];
      e.ovf  = (exact > 64'sd2147483647) || (exact < -64'sd2147483648);
      e.cyc  = 0;
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
      end
   endtask

   // Drives one start pulse at the current negedge; optionally scores it.
   task automatic issue(input logic [31:0] x, input logic [31:0] y,
                        input logic ci, input logic s, input bit push);
      exp_t e;
      start = 1'b1; a = x; b = y; cin = ci; sub = s;
      if (push) begin
         e     = model(x, y, ci, s);
         e.cyc = cyc + 9;
         exp_q.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
      a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
   endtask

   task automatic wait_done(input string name);
      for (int i = 0; i < 20; i++) begin
         if (done) return;
         @(negedge clk);
      end
      checks++;
      errors++;
      $display("FAIL %s: timeout waiting for done", name);
   endtask

   // Monitor: sample just after each rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (rst) begin
            run_len = 0;
         end else begin
            if (busy) run_len++;
            else if (run_len != 0) begin
               chk("busy_len", 32'(run_len), 32'd8);
               run_len = 0;
            end
            if (done) begin
               chk("busy_in_done", 32'(busy), 32'd0);
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_done: got sum 0x%08h expected no result", sum);
               end else begin
                  e = exp_q.pop_front();
                  chk("sum",  sum, e.sum);
                  chk("cout", 32'(cout), 32'(e.cout));
                  chk("ovf",  32'(ovf), 32'(e.ovf));
                  chk("latency_cyc", 32'(cyc), 32'(e.cyc));
               end
            end
         end
      end
   end

   initial begin
      rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sum",  sum, 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_ovf",  32'(ovf), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Nibble carry propagation, full chain, subtract.
      issue(32'h0000000F, 32'h00000001, 1'b0, 1'b0, 1); wait_done("carry4");
      @(negedge clk);
      issue(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1); wait_done("chain");
      @(negedge clk);
      issue(32'd5, 32'd7, 1'b0, 1'b1, 1); wait_done("sub");
      // Back-to-back from the DONE cycle.
      issue(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1); wait_done("b2b_ovf");
      @(negedge clk);

      // Start 3 cycles into RUN must be ignored.
      issue(32'h0000_1234, 32'h0000_4321, 1'b1, 1'b0, 1);
      repeat (2) @(negedge clk);
      start = 1'b1; a = 32'hDEADBEEF; b = 32'h01234567; sub = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("ignored_start");
      @(negedge clk);
      @(negedge clk);
      chk("idle_hold_sum", sum, 32'h0000_5556);

      // Reset during the 4th RUN cycle aborts everything.
      issue(32'hAAAA5555, 32'h12345678, 1'b0, 1'b0, 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_sum",  sum, 32'd0);
      chk("abort_cout", 32'(cout), 32'd0);
      chk("abort_ovf",  32'(ovf), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      issue(32'h12345678, 32'h11111111, 1'b0, 1'b0, 1); wait_done("post_rst");
      @(negedge clk);

      // Random operations, mixing back-to-back, idle gaps and ignored starts.
      for (int n = 0; n < 40; n++) begin
         issue($urandom, $urandom, 1'($urandom), 1'($urandom), 1);
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
         wait_done("random");
         if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      @(negedge clk);
      repeat (12) @(negedge clk);

      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending results expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
